alu_operand_loader: RTL

- Upstream stage of the TinyTapeout ALU top: assembles one ALU command (opcode, operand A, operand B) from bytes strobed in over the dedicated input pins.
- Presents the complete command to the ALU datapath over a valid/ready handshake.
- Synchronises and edge-detects the asynchronous pin strobe.
- Flags protocol errors with sticky bits that are readable on the status outputs.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/tt_sync_edge.sv | 28 ++
 rtl/alu_operand_loader.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: loader FSM states, opcode space and command byte layout.
package alu_pkg;

  localparam int DATA_W    = 8;
  localparam int OP_W      = 4;
  localparam int NUM_OPS   = 12;
  localparam int UNARY_BIT = 7;

  typedef enum logic [1:0] {
    S_OP    = 2'd0,
    S_A     = 2'd1,
    S_B     = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd7;
  localparam logic [OP_W-1:0] OP_INC  = 4'd8;
  localparam logic [OP_W-1:0] OP_DEC  = 4'd9;
  localparam logic [OP_W-1:0] OP_CMP  = 4'd10;
  localparam logic [OP_W-1:0] OP_PASS = 4'd11;

endpackage

// File: rtl/tt_sync_edge.sv
// Two-flop pin synchroniser plus registered rising-edge detector.
// A pin rise yields a one-cycle pulse three clk edges later; no backpressure.
module tt_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= pin;
      sync   <= meta;
      sync_d <= sync;
      pulse  <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Assembles opcode/A/B from strobed pin bytes; valid rises the cycle after the last byte.
// Holds the command until alu_ready; bytes arriving while pending are dropped and flagged.
module alu_operand_loader #(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int OP_W    = alu_pkg::OP_W,
  parameter int NUM_OPS = alu_pkg::NUM_OPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_strobe,
  input  logic              clr_err,
  input  logic              alu_ready,
  output logic              alu_valid,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              busy,
  output logic [1:0]        state_dbg,
  output logic              err_illegal,
  output logic              err_overrun,
  output logic [7:0]        issue_cnt
);

  import alu_pkg::*;

  state_t          state;
  logic            stb;
  logic            unary;
  logic [OP_W-1:0] op_in;
  logic            op_legal;

  tt_sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (in_strobe),
    .pulse (stb)
  );

  assign op_in     = in_data[OP_W-1:0];
  assign op_legal  = 32'(op_in) < NUM_OPS;
  assign busy      = (state != S_OP);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_OP;
      alu_valid   <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      unary       <= 1'b0;
      err_illegal <= 1'b0;
      err_overrun <= 1'b0;
      issue_cnt   <= 8'd0;
    end else begin
      // Clear first so a same-cycle error assignment below takes priority.
      if (clr_err) begin
        err_illegal <= 1'b0;
        err_overrun <= 1'b0;
      end
      case (state)
        S_OP: begin
          if (stb) begin
            if (!op_legal) begin
              err_illegal <= 1'b1;
            end else begin
              alu_op <= op_in;
              unary  <= in_data[UNARY_BIT];
              state  <= S_A;
            end
          end
        end
        S_A: begin
          if (stb) begin
            alu_a <= in_data;
            if (unary) begin
              alu_b     <= '0;
              alu_valid <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              state <= S_B;
            end
          end
        end
        S_B: begin
          if (stb) begin
            alu_b     <= in_data;
            alu_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (stb) begin
            err_overrun <= 1'b1;
          end
          if (alu_valid && alu_ready) begin
            alu_valid <= 1'b0;
            issue_cnt <= issue_cnt + 8'd1;
            state     <= S_OP;
          end
        end
        default: state <= S_OP;
      endcase
    end
  end

endmodule
